// File: rtl/addsub_nibble_sequencer_if.sv
// Request/response bundle for addsub_nibble_sequencer.
// The ovf signal exists only when ADDSUB_OVF_EN is defined.
interface addsub_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef ADDSUB_OVF_EN
    logic             ovf;
`endif

    // master: requester and consumer side; slave: the sequencer itself
    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, cout
`ifdef ADDSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, cout
`ifdef ADDSUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/addsub_nibble_sequencer.sv
// Serial add/subtract: one 4-bit slice per clock, LSB nibble first, carry chained across cycles.
// Optional signed-overflow output is enabled with ADDSUB_OVF_EN.
module addsub_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    addsub_nibble_sequencer_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             in_ready_q;
`ifdef ADDSUB_OVF_EN
    logic             ovf_q;
`endif

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [4:0] sum;
    logic       last;

    // Subtract is a + ~b + 1: the +1 comes from the carry seeded at accept.
    always_comb begin
        a_nib = a_q[idx*4 +: 4];
        b_nib = mode_q ? b_q[idx*4 +: 4] : ~b_q[idx*4 +: 4];
        sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
        last  = (idx == IDX_W'(NSLICE - 1));
    end

    // NOTE: all state is registered with non-blocking assignments under an
    // asynchronous reset so an abort clears outputs without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            idx         <= '0;
            carry       <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ADDSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        mode_q     <= bus.mode;
                        idx        <= '0;
                        carry      <= ~bus.mode;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx*4 +: 4] <= sum[3:0];
                    carry                <= sum[4];
                    if (last) begin
                        idx         <= '0;
                        cout_q      <= mode_q ? sum[4] : ~sum[4];
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef ADDSUB_OVF_EN
                        // sum[3] is the MSB of the final result.
                        ovf_q <= (mode_q ? (a_q[WIDTH-1] == b_q[WIDTH-1])
                                         : (a_q[WIDTH-1] != b_q[WIDTH-1]))
                                 && (sum[3] != a_q[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
`ifdef ADDSUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Self-checking bench for addsub_nibble_sequencer (WIDTH=16): directed vectors,
// multi-cycle corner sequences, and random operations against an arithmetic model.
module tb_addsub_nibble_sequencer;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    addsub_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    addsub_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        mode;
        logic [15:0] exp_result;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference: unsigned wrap for result, signed range test for ovf.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic mode,
                                  output logic [15:0] r, output logic c, output logic o);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        if (mode) begin
            r  = 16'((ua + ub) % 65536);
            c  = (ua + ub) >= 65536;
            sr = sa + sb;
        end else begin
            r  = 16'((ua - ub + 65536) % 65536);
            c  = ua < ub;
            sr = sa - sb;
        end
        o = (sr > 32767) || (sr < -32768);
    endfunction

    // Called at a negedge with the block idle; returns at a negedge after the transfer.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic mode, input logic [15:0] er, input logic ec,
                          input logic eo, input int hold, input bit junk);
        int lat;
        check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.mode     = mode;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.mode     = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".result"}, 32'(bus.result), 32'(er));
        check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
`ifdef ADDSUB_OVF_EN
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'($urandom);
                bus.b        = 16'($urandom);
                bus.mode     = 1'($urandom);
            end
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_result"}, 32'(bus.result), 32'(er));
            check({tag, ".hold_cout"}, 32'(bus.cout), 32'(ec));
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [15:0] ra, rb, mr;
        logic        rm, mc, mo;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b1, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[3] = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.cout", 32'(bus.cout), 32'd0);
`ifdef ADDSUB_OVF_EN
        check("reset.ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mode,
                   vecs[i].exp_result, vecs[i].exp_cout, vecs[i].exp_ovf, 0, 1'b0);

        // Consumer stalls 5 clocks while a new request is presented.
        run_op("stall", 16'h1234, 16'h0FFF, 1'b1, 16'h2233, 1'b0, 1'b0, 5, 1'b1);

        // Abort mid-operation: two nibbles written, then asynchronous reset.
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.mode     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.out_valid", 32'(bus.out_valid), 32'd0);
        check("abort.result", 32'(bus.result), 32'd0);
        check("abort.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_abort", 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = (i % 8 == 0) ? ra : 16'($urandom);
            rm = 1'($urandom);
            model(ra, rb, rm, mr, mc, mo);
            run_op($sformatf("rand%0d", i), ra, rb, rm, mr, mc, mo,
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
